// File: rtl/stc_frame_aligner_if.sv
`default_nettype none
// ============================================================================
// Module   : stc_frame_aligner_if
// Brief    : Sample-in / paced-sample-out bundle for stc_frame_aligner.
// Revision : 1.0 - initial release
// ============================================================================
interface stc_frame_aligner_if #(
   parameter int WIDTH  = 18,
   parameter int NUM_CH = 2,
   parameter int IDX_W  = 14
);
   logic                      clkEn;
   logic                      start;
   logic                      valid;
   logic [NUM_CH*WIDTH-1:0]   dinReal;
   logic [NUM_CH*WIDTH-1:0]   dinImag;
   logic                      clkEnOut;
   logic                      interpolate;
   logic                      frameValid;
   logic [IDX_W-1:0]          frameIndex;
   logic [NUM_CH*WIDTH-1:0]   doutReal;
   logic [NUM_CH*WIDTH-1:0]   doutImag;
   logic                      overflow;
   logic [7:0]                resyncCount;

   modport master (
      output clkEn, start, valid, dinReal, dinImag,
      input  clkEnOut, interpolate, frameValid, frameIndex,
             doutReal, doutImag, overflow, resyncCount
   );

   modport slave (
      input  clkEn, start, valid, dinReal, dinImag,
      output clkEnOut, interpolate, frameValid, frameIndex,
             doutReal, doutImag, overflow, resyncCount
   );
endinterface
`default_nettype wire

// File: rtl/stc_frame_aligner.sv
`default_nettype none
// ============================================================================
// Module   : stc_frame_aligner
// Brief    : Tags samples with a start-anchored frame index, buffers them and
//            replays them at a paced rate with interpolate/frame-valid strobes.
// Revision : 1.0 - initial release
// ============================================================================
module stc_frame_aligner #(
   parameter int WIDTH           = 18,
   parameter int NUM_CH          = 2,
   parameter int START_OFFSET    = 0,
   parameter int FRAME_LEN       = 12800,
   parameter int PILOT_LEN       = 512,
   parameter int SAMPLES_PER_BIT = 4,
   parameter int CLKS_PER_OUTPUT = 4,
   parameter int FIFO_DEPTH      = 1024
) (
   input  logic                 clk,
   input  logic                 aresetn,
   stc_frame_aligner_if.slave   bus
);

   localparam int IDX_W    = $clog2(FRAME_LEN);
   localparam int DW       = NUM_CH * WIDTH;
   localparam int WORD_W   = IDX_W + 2 * DW;
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int PACE_W   = (CLKS_PER_OUTPUT > 1) ? $clog2(CLKS_PER_OUTPUT) : 1;
   localparam int FV_START = (PILOT_LEN > SAMPLES_PER_BIT) ? PILOT_LEN - SAMPLES_PER_BIT : 0;

   localparam logic [IDX_W-1:0]  C_OFFSET   = IDX_W'(START_OFFSET);
   localparam logic [IDX_W-1:0]  C_LAST     = IDX_W'(FRAME_LEN - 1);
   localparam logic [IDX_W-1:0]  C_BIT_MASK = IDX_W'(SAMPLES_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  C_FV_START = IDX_W'(FV_START);
   localparam logic [AW:0]       C_DEPTH    = (AW+1)'(FIFO_DEPTH);
   localparam logic [PACE_W-1:0] C_PACE_RLD = PACE_W'(CLKS_PER_OUTPUT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;

   function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] v);
      return (v == C_LAST) ? '0 : v + IDX_W'(1);
   endfunction

   logic [1:0]          r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [7:0]          r_resync;
   logic                r_ovf;
   logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [AW:0]         r_count;
   logic [PACE_W-1:0]   r_pace;
   logic                r_pop;
   logic [WORD_W-1:0]   r_rd_word;
   logic                r_ceo;
   logic                r_interp;
   logic                r_fv;
   logic [IDX_W-1:0]    r_fidx;
   logic [DW-1:0]       r_dre;
   logic [DW-1:0]       r_dim;

   logic [IDX_W-1:0]    w_smp_idx;
   logic [IDX_W-1:0]    w_pred_idx;
   logic                w_accept;
   logic                w_resync;
   logic                w_empty;
   logic                w_full;
   logic                w_pop;
   logic                w_wr;
   logic [IDX_W-1:0]    w_rd_idx;

   // A sample arriving with start still belongs to the current state, so the
   // resync prediction looks one index past it.
   assign w_smp_idx  = (r_state == S_ARMED) ? C_OFFSET : f_next_idx(r_idx);
   assign w_accept   = bus.clkEn & bus.valid & (r_state != S_IDLE);
   assign w_pred_idx = w_accept ? f_next_idx(w_smp_idx) : w_smp_idx;
   assign w_resync   = bus.clkEn & bus.start & (r_state == S_RUN) & (w_pred_idx != C_OFFSET);

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == C_DEPTH);
   assign w_pop      = ~w_empty & (r_pace == '0);
   assign w_wr       = w_accept & (~w_full | w_pop);
   assign w_rd_idx   = r_rd_word[WORD_W-1 -: IDX_W];

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_resync <= '0;
         r_ovf    <= 1'b0;
      end else if (bus.clkEn) begin
         if (bus.start)
            r_state <= S_ARMED;
         else if (w_accept && r_state == S_ARMED)
            r_state <= S_RUN;
         // The index keeps counting through drops so survivors stay correct.
         if (w_accept)
            r_idx <= w_smp_idx;
         if (w_accept && w_full && !w_pop)
            r_ovf <= 1'b1;
         if (w_resync && r_resync != 8'hFF)
            r_resync <= r_resync + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= {w_smp_idx, bus.dinImag, bus.dinReal};
      if (w_pop)
         r_rd_word <= r_mem[r_rd_ptr];
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_pace   <= '0;
         r_pop    <= 1'b0;
      end else begin
         r_pop <= w_pop;
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_pop)
            r_pace <= C_PACE_RLD;
         else if (r_pace != '0)
            r_pace <= r_pace - PACE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_ceo    <= 1'b0;
         r_interp <= 1'b0;
         r_fv     <= 1'b0;
         r_fidx   <= '0;
         r_dre    <= '0;
         r_dim    <= '0;
      end else begin
         r_ceo    <= r_pop;
         r_interp <= r_pop & ((w_rd_idx & C_BIT_MASK) == '0);
         r_fv     <= r_pop & (w_rd_idx >= C_FV_START);
         if (r_pop) begin
            r_fidx <= w_rd_idx;
            r_dim  <= r_rd_word[2*DW-1 -: DW];
            r_dre  <= r_rd_word[DW-1:0];
         end
      end
   end

   assign bus.clkEnOut    = r_ceo;
   assign bus.interpolate = r_interp;
   assign bus.frameValid  = r_fv;
   assign bus.frameIndex  = r_fidx;
   assign bus.doutReal    = r_dre;
   assign bus.doutImag    = r_dim;
   assign bus.overflow    = r_ovf;
   assign bus.resyncCount = r_resync;

endmodule
`default_nettype wire

// File: tb/tb_stc_frame_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_stc_frame_aligner
// Brief    : Two aligner instances driven in lockstep, checked against a
//            queue-based reference model every cycle plus scenario checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stc_frame_aligner;

   localparam int SPB = 4;
   localparam int CPO = 4;
   localparam int P_OFF   [2] = '{0, 100};
   localparam int P_FL    [2] = '{1024, 160};
   localparam int P_PL    [2] = '{512, 32};
   localparam int P_DEPTH [2] = '{1024, 16};

   typedef struct {
      int          idx;
      logic [35:0] re;
      logic [35:0] im;
   } word_t;

   logic        clk;
   logic        aresetn;
   logic        t_ce, t_st, t_v;
   logic [35:0] t_re, t_im;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   stc_frame_aligner_if #(.WIDTH(18), .NUM_CH(2), .IDX_W(10)) if0 ();
   stc_frame_aligner_if #(.WIDTH(18), .NUM_CH(2), .IDX_W(8))  if1 ();

   assign if0.clkEn = t_ce;  assign if0.start = t_st;  assign if0.valid = t_v;
   assign if0.dinReal = t_re; assign if0.dinImag = t_im;
   assign if1.clkEn = t_ce;  assign if1.start = t_st;  assign if1.valid = t_v;
   assign if1.dinReal = t_re; assign if1.dinImag = t_im;

   stc_frame_aligner #(
      .WIDTH(18), .NUM_CH(2), .START_OFFSET(0), .FRAME_LEN(1024), .PILOT_LEN(512),
      .SAMPLES_PER_BIT(SPB), .CLKS_PER_OUTPUT(CPO), .FIFO_DEPTH(1024)
   ) u0 (.clk(clk), .aresetn(aresetn), .bus(if0));

   stc_frame_aligner #(
      .WIDTH(18), .NUM_CH(2), .START_OFFSET(100), .FRAME_LEN(160), .PILOT_LEN(32),
      .SAMPLES_PER_BIT(SPB), .CLKS_PER_OUTPUT(CPO), .FIFO_DEPTH(16)
   ) u1 (.clk(clk), .aresetn(aresetn), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   word_t q0[$];
   word_t q1[$];
   int    st[2], nxt[2], pace[2], rsc[2];
   bit    ovf[2], p_v[2];
   word_t p_w[2];
   bit    e_ceo[2], e_int[2], e_fv[2];
   int    e_idx[2];
   logic [35:0] e_re[2], e_im[2];

   // statistics gathered from DUT outputs
   int n_out[2], n_int[2], first_fv[2], first_idx[2], first_itp[2];
   bit mono_on = 0, gap_on = 0;
   int last_idx1, last_t0;

   function automatic int qsize(input int m);
      return (m == 0) ? q0.size() : q1.size();
   endfunction

   task automatic qpush(input int m, input word_t w);
      if (m == 0) q0.push_back(w); else q1.push_back(w);
   endtask

   task automatic qpop(input int m, output word_t w);
      if (m == 0) w = q0.pop_front(); else w = q1.pop_front();
   endtask

   task automatic model_reset(input int m);
      if (m == 0) q0.delete(); else q1.delete();
      st[m] = 0; nxt[m] = 0; pace[m] = 0; rsc[m] = 0; ovf[m] = 0; p_v[m] = 0;
      e_ceo[m] = 0; e_int[m] = 0; e_fv[m] = 0; e_idx[m] = 0; e_re[m] = '0; e_im[m] = '0;
   endtask

   task automatic model_step(input int m);
      int    old_st, idx;
      word_t w;
      // what was popped on the previous edge becomes visible now
      e_ceo[m] = p_v[m];
      e_int[m] = 0;
      e_fv[m]  = 0;
      if (p_v[m]) begin
         e_idx[m] = p_w[m].idx;
         e_re[m]  = p_w[m].re;
         e_im[m]  = p_w[m].im;
         e_int[m] = (p_w[m].idx % SPB) == 0;
         e_fv[m]  = p_w[m].idx >= P_PL[m] - SPB;
      end
      if (qsize(m) > 0 && pace[m] == 0) begin
         qpop(m, w);
         p_w[m] = w; p_v[m] = 1; pace[m] = CPO - 1;
      end else begin
         p_v[m] = 0;
         if (pace[m] > 0) pace[m]--;
      end
      if (t_ce) begin
         old_st = st[m];
         if (t_v && old_st != 0) begin
            idx    = (old_st == 1) ? P_OFF[m] : nxt[m];
            nxt[m] = (idx + 1) % P_FL[m];
            w.idx = idx; w.re = t_re; w.im = t_im;
            if (qsize(m) < P_DEPTH[m]) qpush(m, w); else ovf[m] = 1;
            if (old_st == 1) st[m] = 2;
         end
         if (t_st) begin
            if (old_st == 2 && nxt[m] != P_OFF[m] && rsc[m] < 255) rsc[m]++;
            st[m] = 1;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic sample(input int m, output logic ceo, output logic itp, output logic fv,
                         output logic ov, output int fi, output logic [35:0] re,
                         output logic [35:0] im, output logic [7:0] rc);
      if (m == 0) begin
         ceo = if0.clkEnOut; itp = if0.interpolate; fv = if0.frameValid; ov = if0.overflow;
         fi = int'(if0.frameIndex); re = if0.doutReal; im = if0.doutImag; rc = if0.resyncCount;
      end else begin
         ceo = if1.clkEnOut; itp = if1.interpolate; fv = if1.frameValid; ov = if1.overflow;
         fi = int'(if1.frameIndex); re = if1.doutReal; im = if1.doutImag; rc = if1.resyncCount;
      end
   endtask

   task automatic check_all(input int m);
      logic ceo, itp, fv, ov; int fi; logic [35:0] re, im; logic [7:0] rc;
      sample(m, ceo, itp, fv, ov, fi, re, im, rc);
      chk($sformatf("u%0d.clkEnOut", m),    64'(ceo), 64'(e_ceo[m]));
      chk($sformatf("u%0d.interpolate", m), 64'(itp), 64'(e_int[m]));
      chk($sformatf("u%0d.frameValid", m),  64'(fv),  64'(e_fv[m]));
      chk($sformatf("u%0d.frameIndex", m),  64'(fi),  64'(e_idx[m]));
      chk($sformatf("u%0d.doutReal", m),    64'(re),  64'(e_re[m]));
      chk($sformatf("u%0d.doutImag", m),    64'(im),  64'(e_im[m]));
      chk($sformatf("u%0d.overflow", m),    64'(ov),  64'(ovf[m]));
      chk($sformatf("u%0d.resyncCount", m), 64'(rc),  64'(rsc[m]));
      if (ceo) begin
         n_out[m]++;
         if (itp) n_int[m]++;
         if (fv && first_fv[m] < 0) first_fv[m] = fi;
         if (first_idx[m] < 0) begin first_idx[m] = fi; first_itp[m] = int'(itp); end
         if (mono_on && m == 1) begin
            if (last_idx1 >= 0) chk("u1.indexIncreasing", 64'(fi > last_idx1), 64'd1);
            last_idx1 = fi;
         end
         if (gap_on && m == 0) begin
            if (last_t0 >= 0) chk("u0.strobeGap", 64'(cyc - last_t0), 64'(CPO));
            last_t0 = cyc;
         end
      end
   endtask

   task automatic check_zero(input int m);
      logic ceo, itp, fv, ov; int fi; logic [35:0] re, im; logic [7:0] rc;
      sample(m, ceo, itp, fv, ov, fi, re, im, rc);
      chk($sformatf("u%0d.rstOutputs", m),
          64'({ceo, itp, fv, ov, rc} != 0 || fi != 0 || re != 0 || im != 0), 64'd0);
   endtask

   task automatic clear_stats();
      for (int m = 0; m < 2; m++) begin
         n_out[m] = 0; n_int[m] = 0; first_fv[m] = -1; first_idx[m] = -1; first_itp[m] = -1;
      end
      last_idx1 = -1; last_t0 = -1;
   endtask

   task automatic tick();
      @(posedge clk);
      for (int m = 0; m < 2; m++)
         if (!aresetn) model_reset(m); else model_step(m);
      cyc++;
      #1;
      check_all(0);
      check_all(1);
   endtask

   task automatic drive(input logic ce, input logic s, input logic v);
      logic [63:0] r;
      t_ce = ce; t_st = s; t_v = v;
      r = {$urandom, $urandom}; t_re = r[35:0];
      r = {$urandom, $urandom}; t_im = r[35:0];
      tick();
   endtask

   task automatic do_reset();
      t_ce = 0; t_st = 0; t_v = 0;
      aresetn = 1'b0;
      repeat (3) tick();
      aresetn = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      t_ce = 0; t_st = 0; t_v = 0; t_re = '0; t_im = '0;
      aresetn = 1'b0;
      for (int m = 0; m < 2; m++) model_reset(m);
      clear_stats();
      do_reset();

      // valid samples without a start must be ignored
      repeat (20) drive(1, 0, 1);
      repeat (10) drive(0, 0, 0);
      chk("u0.noStartOutputs", 64'(n_out[0]), 64'd0);
      chk("u1.noStartOutputs", 64'(n_out[1]), 64'd0);

      // one start then 600 back-to-back samples
      clear_stats();
      gap_on = 1;
      drive(1, 1, 0);
      repeat (600) drive(1, 0, 1);
      repeat (2500) drive(0, 0, 0);
      gap_on = 0;
      chk("u0.outputCount", 64'(n_out[0]), 64'd600);
      chk("u0.interpCount", 64'(n_int[0]), 64'd150);
      chk("u0.firstFrameValidIdx", 64'(first_fv[0]), 64'd508);
      chk("u0.firstIndex", 64'(first_idx[0]), 64'd0);
      chk("u1.firstIndex", 64'(first_idx[1]), 64'd100);
      chk("u1.firstInterp", 64'(first_itp[1]), 64'd1);
      chk("u1.overflowSticky", 64'(if1.overflow), 64'd1);

      // short burst into the small FIFO: survivors keep increasing indices
      do_reset();
      clear_stats();
      mono_on = 1;
      drive(1, 1, 0);
      repeat (40) drive(1, 0, 1);
      repeat (200) drive(0, 0, 0);
      mono_on = 0;
      chk("u1.burstOverflow", 64'(if1.overflow), 64'd1);
      chk("u1.burstDropped", 64'(n_out[1] < 40), 64'd1);
      chk("u0.burstNoOverflow", 64'(if0.overflow), 64'd0);

      // re-start mid-frame, then exactly one frame later
      do_reset();
      drive(1, 1, 0);
      repeat (50) drive(1, 0, 1);
      drive(1, 1, 0);
      chk("u0.resyncMid", 64'(if0.resyncCount), 64'd1);
      chk("u1.resyncMid", 64'(if1.resyncCount), 64'd1);
      repeat (160) drive(1, 0, 1);
      drive(1, 1, 0);
      chk("u1.resyncAligned", 64'(if1.resyncCount), 64'd1);
      chk("u0.resyncOffFrame", 64'(if0.resyncCount), 64'd2);
      repeat (1000) drive(0, 0, 0);

      // randomized traffic, including start/valid coincidences
      do_reset();
      drive(1, 1, 0);
      repeat (3000)
         drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8));

      // asynchronous reset with a busy FIFO
      @(posedge clk);
      cyc++;
      for (int m = 0; m < 2; m++) model_step(m);
      #3;
      aresetn = 1'b0;
      #1;
      check_zero(0);
      check_zero(1);
      for (int m = 0; m < 2; m++) model_reset(m);
      repeat (3) tick();
      aresetn = 1'b1;
      clear_stats();
      repeat (30) drive(1, 0, 1);
      repeat (10) drive(0, 0, 0);
      chk("u0.postResetSilent", 64'(n_out[0]), 64'd0);
      chk("u1.postResetSilent", 64'(n_out[1]), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
